// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared state encoding and colour constants for race_frame_ctrl
package race_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_RUN       = 3'd2,
      ST_CRASH     = 3'd3,
      ST_OVER      = 3'd4,
      ST_PAUSE     = 3'd5
   } state_t;

   localparam logic [11:0] COL_WHITE = 12'hfff;
   localparam logic [11:0] COL_RED   = 12'hf00;
   localparam logic [11:0] COL_GREEN = 12'h0f0;

   localparam logic [1:0] COUNTDOWN_START = 2'd3;

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - registered rising-edge detector with one-cycle registered pulse
module rise_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);

   logic q;
   logic armed;

   // armed stays low until the input is seen low, so a level held through reset never fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= 1'b0;
         armed <= 1'b0;
         pulse <= 1'b0;
      end else begin
         q     <= d;
         armed <= armed | ~d;
         pulse <= d & ~q & armed;
      end
   end

endmodule

// File: rtl/race_frame_ctrl.sv
// rtl/race_frame_ctrl.sv - per-frame game sequencer and track drawer configuration
// Optional PAUSE state and pause_in port enabled by RACE_PAUSE_EN.
module race_frame_ctrl
   import race_pkg::*;
#(
   parameter int COUNT_FRAMES  = 60,
   parameter int ACCEL_FRAMES  = 120,
   parameter int INIT_SPEED    = 1,
   parameter int MAX_SPEED     = 8,
   parameter int SCROLL_PERIOD = 64,
   parameter int CRASH_FRAMES  = 64
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        vblnk_in,
   input  logic        start_in,
   input  logic        crash_in,
`ifdef RACE_PAUSE_EN
   input  logic        pause_in,
`endif
   output logic        frame_tick,
   output logic [2:0]  game_state,
   output logic [1:0]  countdown,
   output logic [3:0]  speed,
   output logic [10:0] scroll_offset,
   output logic [11:0] border_rgb,
   output logic        markers_en
);

   state_t      state, next_state;
   logic        vblnk_rise, start_rise;
   logic        start_pend, crash_pend, pause_pend;
   logic [15:0] cnt, accel_cnt;
   logic [11:0] sum, sum_wrap;

   rise_edge u_vblnk (.clk(pclk), .rst_n(rst_n), .d(vblnk_in), .pulse(vblnk_rise));
   rise_edge u_start (.clk(pclk), .rst_n(rst_n), .d(start_in), .pulse(start_rise));

`ifdef RACE_PAUSE_EN
   logic pause_rise;
   rise_edge u_pause (.clk(pclk), .rst_n(rst_n), .d(pause_in), .pulse(pause_rise));

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) pause_pend <= 1'b0;
      else        pause_pend <= pause_rise | (pause_pend & ~frame_tick);
   end
`else
   assign pause_pend = 1'b0;
`endif

   // Events arriving in the tick cycle itself are kept for the following frame
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_tick <= 1'b0;
         start_pend <= 1'b0;
         crash_pend <= 1'b0;
      end else begin
         frame_tick <= vblnk_rise;
         start_pend <= start_rise | (start_pend & ~frame_tick);
         crash_pend <= crash_in | (crash_pend & ~frame_tick);
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n)          state <= ST_IDLE;
      else if (frame_tick) state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (start_pend) next_state = ST_COUNTDOWN;
         ST_COUNTDOWN: if (cnt == 16'(COUNT_FRAMES - 1) && countdown == 2'd0)
                          next_state = ST_RUN;
         ST_RUN:       if (crash_pend)      next_state = ST_CRASH;
                       else if (pause_pend) next_state = ST_PAUSE;
         ST_CRASH:     if (cnt == 16'(CRASH_FRAMES - 1)) next_state = ST_OVER;
         ST_OVER:      if (start_pend) next_state = ST_COUNTDOWN;
         ST_PAUSE:     if (pause_pend) next_state = ST_RUN;
         default:      next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      border_rgb = COL_WHITE;
      markers_en = 1'b0;
      case (state)
         ST_RUN:   markers_en = 1'b1;
         ST_CRASH: border_rgb = cnt[3] ? COL_WHITE : COL_RED;
         ST_OVER:  border_rgb = COL_RED;
         ST_PAUSE: begin
            border_rgb = COL_GREEN;
            markers_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign game_state = state;
   assign sum        = {1'b0, scroll_offset} + {8'd0, speed};
   assign sum_wrap   = (sum >= 12'(SCROLL_PERIOD)) ? sum - 12'(SCROLL_PERIOD) : sum;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         accel_cnt     <= '0;
         countdown     <= COUNTDOWN_START;
         speed         <= '0;
         scroll_offset <= '0;
      end else if (frame_tick) begin
         case (state)
            ST_IDLE, ST_OVER: if (start_pend) begin
               cnt           <= '0;
               countdown     <= COUNTDOWN_START;
               speed         <= '0;
               scroll_offset <= '0;
            end
            ST_COUNTDOWN: if (cnt == 16'(COUNT_FRAMES - 1)) begin
               cnt <= '0;
               if (countdown == 2'd0) begin
                  speed         <= 4'(INIT_SPEED);
                  scroll_offset <= '0;
                  accel_cnt     <= '0;
               end else begin
                  countdown <= countdown - 2'd1;
               end
            end else begin
               cnt <= cnt + 16'd1;
            end
            ST_RUN: if (next_state == ST_CRASH) begin
               speed <= '0;
               cnt   <= '0;
            end else if (next_state == ST_RUN) begin
               scroll_offset <= sum_wrap[10:0];
               if (accel_cnt == 16'(ACCEL_FRAMES - 1)) begin
                  accel_cnt <= '0;
                  if (speed < 4'(MAX_SPEED)) speed <= speed + 4'd1;
               end else begin
                  accel_cnt <= accel_cnt + 16'd1;
               end
            end
            ST_CRASH: cnt <= cnt + 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_race_frame_ctrl.sv
// tb/tb_race_frame_ctrl.sv - directed table-driven bench for race_frame_ctrl
module tb_race_frame_ctrl;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vblnk_in = 1'b0;
   logic        start_in = 1'b0;
   logic        crash_in = 1'b0;
   logic        pause_in = 1'b0;
   logic        frame_tick;
   logic [2:0]  game_state;
   logic [1:0]  countdown;
   logic [3:0]  speed;
   logic [10:0] scroll_offset;
   logic [11:0] border_rgb;
   logic        markers_en;

   int n_cmp = 0;
   int n_err = 0;

   localparam int S_IDLE = 0, S_CD = 1, S_RUN = 2, S_CRASH = 3, S_OVER = 4, S_PAUSE = 5;

   typedef struct { int st; int cd; } cd_vec_t;
   typedef struct { int off; int spd; } run_vec_t;
   cd_vec_t  cd_tab[8];
   run_vec_t run_tab[32];

   race_frame_ctrl #(
      .COUNT_FRAMES(2), .ACCEL_FRAMES(4), .INIT_SPEED(1),
      .MAX_SPEED(8), .SCROLL_PERIOD(64), .CRASH_FRAMES(24)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in), .start_in(start_in),
      .crash_in(crash_in),
`ifdef RACE_PAUSE_EN
      .pause_in(pause_in),
`endif
      .frame_tick(frame_tick), .game_state(game_state), .countdown(countdown),
      .speed(speed), .scroll_offset(scroll_offset), .border_rgb(border_rgb),
      .markers_en(markers_en)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One 10-cycle vblank period; the tick must appear once, 2 cycles after the rise
   task automatic frame();
      int nt = 0;
      int pos = -1;
      vblnk_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge pclk);
         if (i == 5) vblnk_in = 1'b0;
         if (frame_tick) begin
            nt++;
            pos = i;
         end
      end
      chk("tick_count", nt, 1);
      chk("tick_latency", pos, 2);
   endtask

   task automatic pulse(input logic s, input logic c, input logic p);
      @(negedge pclk);
      start_in = s; crash_in = c; pause_in = p;
      @(negedge pclk);
      start_in = 1'b0; crash_in = 1'b0; pause_in = 1'b0;
   endtask

   task automatic start_to_run();
      pulse(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) frame();
      chk("run_entry_state", game_state, S_RUN);
   endtask

   initial begin
      cd_tab = '{'{S_CD,3}, '{S_CD,2}, '{S_CD,2}, '{S_CD,1},
                 '{S_CD,1}, '{S_CD,0}, '{S_CD,0}, '{S_RUN,0}};
      run_tab = '{'{1,1},  '{2,1},  '{3,1},  '{4,2},  '{6,2},  '{8,2},  '{10,2}, '{12,3},
                  '{15,3}, '{18,3}, '{21,3}, '{24,4}, '{28,4}, '{32,4}, '{36,4}, '{40,5},
                  '{45,5}, '{50,5}, '{55,5}, '{60,6}, '{2,6},  '{8,6},  '{14,6}, '{20,7},
                  '{27,7}, '{34,7}, '{41,7}, '{48,8}, '{56,8}, '{0,8},  '{8,8},  '{16,8}};

      repeat (3) @(negedge pclk);
      chk("rst_state", game_state, S_IDLE);
      chk("rst_countdown", countdown, 3);
      chk("rst_speed", speed, 0);
      chk("rst_offset", scroll_offset, 0);
      chk("rst_border", border_rgb, 12'hfff);
      chk("rst_markers", markers_en, 0);
      chk("rst_tick", frame_tick, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge pclk);

      for (int i = 0; i < 3; i++) begin
         frame();
         chk("idle_state", game_state, S_IDLE);
         chk("idle_speed", speed, 0);
         chk("idle_border", border_rgb, 12'hfff);
         chk("idle_markers", markers_en, 0);
      end

      pulse(1'b1, 1'b0, 1'b0);
      frame();
      chk("cd_entry_state", game_state, S_CD);
      chk("cd_entry_digit", countdown, 3);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) pulse(1'b0, 1'b1, 1'b0);
         frame();
         chk("cd_state", game_state, cd_tab[i].st);
         chk("cd_digit", countdown, cd_tab[i].cd);
      end
      chk("run_speed", speed, 1);
      chk("run_markers", markers_en, 1);
      chk("run_offset", scroll_offset, 0);

      for (int i = 0; i < 32; i++) begin
         frame();
         chk("run_tab_offset", scroll_offset, run_tab[i].off);
         chk("run_tab_speed", speed, run_tab[i].spd);
         chk("run_tab_border", border_rgb, 12'hfff);
      end

      pulse(1'b1, 1'b1, 1'b0);
      frame();
      chk("crash_state", game_state, S_CRASH);
      chk("crash_speed", speed, 0);
      chk("crash_border0", border_rgb, 12'hf00);
      for (int k = 1; k <= 24; k++) begin
         frame();
         chk("crash_seq_state", game_state, (k == 24) ? S_OVER : S_CRASH);
         chk("crash_seq_border", border_rgb,
             (k == 24 || ((k / 8) % 2) == 0) ? 12'hf00 : 12'hfff);
         chk("crash_seq_offset", scroll_offset, 16);
         chk("crash_seq_speed", speed, 0);
      end
      chk("over_markers", markers_en, 0);

      pulse(1'b1, 1'b0, 1'b0);
      frame();
      chk("restart_state", game_state, S_CD);
      chk("restart_digit", countdown, 3);
      chk("restart_offset", scroll_offset, 0);
      chk("restart_border", border_rgb, 12'hfff);
      for (int i = 0; i < 8; i++) frame();
      chk("rerun_state", game_state, S_RUN);
      for (int i = 0; i < 3; i++) frame();
      chk("rerun_offset", scroll_offset, 3);

      begin
         int nt = 0;
         vblnk_in = 1'b1;
         @(negedge pclk);
         rst_n = 1'b0;
         #1;
         chk("midrst_state", game_state, S_IDLE);
         chk("midrst_offset", scroll_offset, 0);
         chk("midrst_speed", speed, 0);
         chk("midrst_markers", markers_en, 0);
         @(negedge pclk);
         rst_n = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (frame_tick) nt++;
         end
         vblnk_in = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (frame_tick) nt++;
         end
         chk("midrst_no_stale_tick", nt, 0);
      end
      frame();
      chk("post_rst_state", game_state, S_IDLE);

`ifdef RACE_PAUSE_EN
      start_to_run();
      frame();
      frame();
      chk("pre_pause_offset", scroll_offset, 2);
      pulse(1'b0, 1'b0, 1'b1);
      frame();
      chk("pause_state", game_state, S_PAUSE);
      chk("pause_border", border_rgb, 12'h0f0);
      chk("pause_markers", markers_en, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) pulse(1'b0, 1'b1, 1'b0);
         frame();
         chk("pause_hold_state", game_state, S_PAUSE);
         chk("pause_hold_offset", scroll_offset, 2);
         chk("pause_hold_speed", speed, 1);
      end
      pulse(1'b0, 1'b0, 1'b1);
      frame();
      chk("resume_state", game_state, S_RUN);
      chk("resume_offset", scroll_offset, 2);
      frame();
      chk("resume_offset1", scroll_offset, 3);
      chk("resume_speed1", speed, 1);
      frame();
      chk("resume_offset2", scroll_offset, 4);
      chk("resume_speed2", speed, 2);
`else
      start_to_run();
      for (int i = 0; i < 3; i++) begin
         pulse(1'b0, 1'b0, 1'b1);
         frame();
         chk("no_pause_state", game_state, S_RUN);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
